// File: rtl/vending_pkg.sv
// Shared types and constants for the stock-tracking vending controller:
// FSM state encoding, change denominations and the product price rule.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        PAYOUT = 2'd2
    } state_t;

    localparam int DENOM_50 = 50;
    localparam int DENOM_10 = 10;
    localparam int DENOM_5  = 5;
    localparam int DENOM_1  = 1;

    function automatic int price(input int k, input int base, input int step);
        return base + (k - 1) * step;
    endfunction

endpackage

// File: rtl/change_payout.sv
// Change hopper sequencer: holds the payout balance and emits one greedy coin
// per cycle until the balance is exhausted.
module change_payout
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [CREDIT_W-1:0] balance,
    output logic [CREDIT_W-1:0] coin,
    output logic                valid,
    output logic                done
);

    logic [CREDIT_W-1:0] remaining;

    function automatic logic [CREDIT_W-1:0] pick(input logic [CREDIT_W-1:0] b);
        if (b >= CREDIT_W'(DENOM_50))      return CREDIT_W'(DENOM_50);
        else if (b >= CREDIT_W'(DENOM_10)) return CREDIT_W'(DENOM_10);
        else if (b >= CREDIT_W'(DENOM_5))  return CREDIT_W'(DENOM_5);
        else if (b >= CREDIT_W'(DENOM_1))  return CREDIT_W'(DENOM_1);
        else                               return '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= balance;
        end else if (remaining != '0) begin
            remaining <= remaining - coin;
        end
    end

    // done flags the coin that empties the balance
    assign coin  = pick(remaining);
    assign valid = (remaining != '0);
    assign done  = valid && (remaining == coin);

endmodule

// File: rtl/vending_machine_stock.sv
// Multi-product vending controller with per-product stock and coin-by-coin change.
// Define VENDING_RESTOCK_EN to add the restock/restock_id refill ports.
module vending_machine_stock
    import vending_pkg::*;
#(
    parameter int NUM_DRINKS = 4,
    parameter int SEL_W      = 3,
    parameter int CREDIT_W   = 7,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3,
    parameter int PRICE_BASE = 10,
    parameter int PRICE_STEP = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CREDIT_W-1:0] coin,
    input  logic                coin_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_valid,
    input  logic                cancel,
`ifdef VENDING_RESTOCK_EN
    input  logic                restock,
    input  logic [SEL_W-1:0]    restock_id,
`endif
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense_valid,
    output logic [SEL_W-1:0]    dispense_id,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                coin_reject,
    output logic                sel_error,
    output logic                insufficient,
    output logic                sold_out,
    output logic                busy
);

    state_t              state, state_nxt;
    logic [STOCK_W-1:0]  stock [NUM_DRINKS];
    logic [STOCK_W-1:0]  sel_stock;
    logic [CREDIT_W:0]   sel_price, coin_sum;
    logic                in_idle, sel_in_range, coin_legal;
    logic                cancel_go, sel_evt, sel_ok, coin_ok, payout_load;
    logic                coin_reject_nxt, sel_error_nxt, sold_out_nxt, insufficient_nxt;
    logic [CREDIT_W-1:0] payout_coin;
    logic                payout_valid, payout_done;

    // Prices that do not fit CREDIT_W+1 bits clamp to all-ones, which no credit can reach
    function automatic logic [CREDIT_W:0] price_sat(input int p);
        if (p < 0 || p >= (1 << (CREDIT_W + 1)) - 1) return '1;
        else                                          return (CREDIT_W+1)'(p);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        in_idle      = (state == IDLE);
        sel_in_range = (sel != '0) && (sel <= SEL_W'(NUM_DRINKS));
        sel_stock    = '0;
        for (int k = 0; k < NUM_DRINKS; k++)
            if (sel == SEL_W'(k + 1)) sel_stock = stock[k];
        sel_price  = price_sat(price(int'(sel), PRICE_BASE, PRICE_STEP));
        coin_sum   = {1'b0, credit} + {1'b0, coin};
        coin_legal = (coin == CREDIT_W'(DENOM_1))  || (coin == CREDIT_W'(DENOM_5)) ||
                     (coin == CREDIT_W'(DENOM_10)) || (coin == CREDIT_W'(DENOM_50));
        // Priority in IDLE: cancel, then selection, then coin
        cancel_go   = in_idle && cancel && (credit != '0);
        sel_evt     = in_idle && !cancel && sel_valid;
        sel_ok      = sel_evt && sel_in_range && (sel_stock != '0) && ({1'b0, credit} >= sel_price);
        coin_ok     = in_idle && !cancel && !sel_valid && coin_valid && coin_legal && !coin_sum[CREDIT_W];
        payout_load = cancel_go || ((state == VEND) && (credit != '0));
        state_nxt   = state;
        unique case (state)
            IDLE:    if (cancel_go) state_nxt = PAYOUT;
                     else if (sel_ok) state_nxt = VEND;
            VEND:    state_nxt = (credit != '0) ? PAYOUT : IDLE;
            PAYOUT:  if (payout_done || !payout_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy             = (state != IDLE);
        change_valid     = (state == PAYOUT) && payout_valid;
        change           = change_valid ? payout_coin : '0;
        coin_reject_nxt  = coin_valid && !coin_ok;
        sel_error_nxt    = sel_evt && !sel_in_range;
        sold_out_nxt     = sel_evt && sel_in_range && (sel_stock == '0);
        insufficient_nxt = sel_evt && sel_in_range && (sel_stock != '0) && ({1'b0, credit} < sel_price);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit         <= '0;
            dispense_valid <= 1'b0;
            dispense_id    <= '0;
            coin_reject    <= 1'b0;
            sel_error      <= 1'b0;
            insufficient   <= 1'b0;
            sold_out       <= 1'b0;
        end else begin
            if (payout_load)  credit <= '0;
            else if (sel_ok)  credit <= credit - sel_price[CREDIT_W-1:0];
            else if (coin_ok) credit <= coin_sum[CREDIT_W-1:0];
            dispense_valid <= sel_ok;
            dispense_id    <= sel_ok ? sel : '0;
            coin_reject    <= coin_reject_nxt;
            sel_error      <= sel_error_nxt;
            insufficient   <= insufficient_nxt;
            sold_out       <= sold_out_nxt;
        end
    end

    // A refill landing on the product being vended overrides the decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DRINKS; k++) stock[k] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int k = 0; k < NUM_DRINKS; k++) begin
                if (sel_ok && (sel == SEL_W'(k + 1))) stock[k] <= stock[k] - STOCK_W'(1);
`ifdef VENDING_RESTOCK_EN
                if (restock && (restock_id == SEL_W'(k + 1))) stock[k] <= '1;
`endif
            end
        end
    end

    change_payout #(.CREDIT_W(CREDIT_W)) u_payout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (payout_load),
        .balance (credit),
        .coin    (payout_coin),
        .valid   (payout_valid),
        .done    (payout_done)
    );

endmodule

// File: tb/tb_vending_machine_stock.sv
// Bench for vending_machine_stock: transaction-level model checked every cycle
// plus directed literal expectations; restock scenario enabled by VENDING_RESTOCK_EN.
module tb_vending_machine_stock;

    localparam int NUM_DRINKS = 4;
    localparam int SEL_W      = 3;
    localparam int CREDIT_W   = 7;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CREDIT_W-1:0] coin = '0;
    logic                coin_valid = 1'b0;
    logic [SEL_W-1:0]    sel = '0;
    logic                sel_valid = 1'b0;
    logic                cancel = 1'b0;
`ifdef VENDING_RESTOCK_EN
    logic                restock = 1'b0;
    logic [SEL_W-1:0]    restock_id = '0;
`endif
    logic [CREDIT_W-1:0] credit;
    logic                dispense_valid;
    logic [SEL_W-1:0]    dispense_id;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;
    logic                coin_reject, sel_error, insufficient, sold_out, busy;

    int n_checks = 0;
    int n_errors = 0;

    vending_machine_stock dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin           (coin),
        .coin_valid     (coin_valid),
        .sel            (sel),
        .sel_valid      (sel_valid),
        .cancel         (cancel),
`ifdef VENDING_RESTOCK_EN
        .restock        (restock),
        .restock_id     (restock_id),
`endif
        .credit         (credit),
        .dispense_valid (dispense_valid),
        .dispense_id    (dispense_id),
        .change         (change),
        .change_valid   (change_valid),
        .coin_reject    (coin_reject),
        .sel_error      (sel_error),
        .insufficient   (insufficient),
        .sold_out       (sold_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: credit, stock, pending vend and a queue of change coins still owed
    int m_credit;
    int m_stock[NUM_DRINKS + 1];
    int m_q[$];
    bit m_vend, m_disp, m_rej, m_serr, m_ins, m_sold, m_acc;
    int m_disp_id, m_s, m_p, m_c;

    function automatic void owe(input int b);
        int r = b;
        while (r > 0) begin
            if (r >= 50)      begin m_q.push_back(50); r -= 50; end
            else if (r >= 10) begin m_q.push_back(10); r -= 10; end
            else if (r >= 5)  begin m_q.push_back(5);  r -= 5;  end
            else              begin m_q.push_back(1);  r -= 1;  end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_credit = 0;
            for (int k = 0; k <= NUM_DRINKS; k++) m_stock[k] = 3;
            m_q.delete();
            m_vend = 0; m_disp = 0; m_disp_id = 0;
            m_rej = 0; m_serr = 0; m_ins = 0; m_sold = 0;
        end else begin
            m_disp = 0; m_disp_id = 0; m_rej = 0; m_serr = 0; m_ins = 0; m_sold = 0; m_acc = 0;
            if (m_vend) begin
                m_vend = 0;
                if (m_credit > 0) begin owe(m_credit); m_credit = 0; end
            end else if (m_q.size() > 0) begin
                void'(m_q.pop_front());
            end else if (cancel) begin
                if (m_credit > 0) begin owe(m_credit); m_credit = 0; end
            end else if (sel_valid) begin
                m_s = int'(sel);
                m_p = 10 + (m_s - 1) * 5;
                if (m_s == 0 || m_s > NUM_DRINKS) m_serr = 1;
                else if (m_stock[m_s] == 0)       m_sold = 1;
                else if (m_credit < m_p)          m_ins = 1;
                else begin
                    m_disp = 1; m_disp_id = m_s; m_stock[m_s]--; m_credit -= m_p; m_vend = 1;
                end
            end else if (coin_valid) begin
                m_c = int'(coin);
                if ((m_c == 1 || m_c == 5 || m_c == 10 || m_c == 50) && (m_credit + m_c <= 127)) begin
                    m_credit += m_c; m_acc = 1;
                end
            end
            if (coin_valid && !m_acc) m_rej = 1;
`ifdef VENDING_RESTOCK_EN
            if (restock && int'(restock_id) >= 1 && int'(restock_id) <= NUM_DRINKS)
                m_stock[int'(restock_id)] = 15;
`endif
        end
    end

    always @(negedge clk) begin
        chk("credit", int'(credit), m_credit);
        chk("dispense_valid", int'(dispense_valid), int'(m_disp));
        chk("dispense_id", int'(dispense_id), m_disp_id);
        chk("change", int'(change), (m_q.size() > 0) ? m_q[0] : 0);
        chk("change_valid", int'(change_valid), int'(m_q.size() > 0));
        chk("coin_reject", int'(coin_reject), int'(m_rej));
        chk("sel_error", int'(sel_error), int'(m_serr));
        chk("insufficient", int'(insufficient), int'(m_ins));
        chk("sold_out", int'(sold_out), int'(m_sold));
        chk("busy", int'(busy), int'(m_vend || m_q.size() > 0));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_coin(input int v);
        coin = CREDIT_W'(v); coin_valid = 1'b1;
        tick();
        coin_valid = 1'b0; coin = '0;
    endtask

    task automatic do_sel(input int s);
        sel = SEL_W'(s); sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0; sel = '0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic buy1();
        do_coin(10);
        do_sel(1);
        chk("buy1_dispense", int'(dispense_valid), 1);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_change_valid", int'(change_valid), 0);
        rst_n = 1'b1;
        tick();

        // 26 credit, product 3 at 20 -> change 5 then 1
        do_coin(10); do_coin(5); do_coin(1); do_coin(10);
        chk("t1_credit", int'(credit), 26);
        do_sel(3);
        chk("t1_disp", int'(dispense_valid), 1);
        chk("t1_id", int'(dispense_id), 3);
        chk("t1_vend_credit", int'(credit), 6);
        tick();
        chk("t1_chg0", int'(change), 5);
        chk("t1_pay_credit", int'(credit), 0);
        tick();
        chk("t1_chg1", int'(change), 1);
        tick();
        chk("t1_done_cv", int'(change_valid), 0);
        chk("t1_done_busy", int'(busy), 0);

        // 50 credit, product 4 at 25 -> 10,10,5; coin during VEND is refused
        do_coin(50);
        do_sel(4);
        chk("t2_id", int'(dispense_id), 4);
        do_coin(5);
        chk("t2_busy_reject", int'(coin_reject), 1);
        chk("t2_chg0", int'(change), 10);
        tick();
        chk("t2_chg1", int'(change), 10);
        tick();
        chk("t2_chg2", int'(change), 5);
        tick();
        chk("t2_idle", int'(busy), 0);

        // illegal coin, bad selection, then cancel
        do_coin(10);
        do_coin(7);
        chk("t3_illegal_reject", int'(coin_reject), 1);
        chk("t3_credit_kept", int'(credit), 10);
        do_sel(5);
        chk("t3_sel_error", int'(sel_error), 1);
        chk("t3_credit", int'(credit), 10);
        do_cancel();
        chk("t3_cancel_chg", int'(change), 10);
        chk("t3_cancel_credit", int'(credit), 0);
        tick();
        chk("t3_idle", int'(busy), 0);

        // insufficient with zero credit; overflow coin refused at 120
        do_sel(2);
        chk("t4_insufficient", int'(insufficient), 1);
        chk("t4_busy", int'(busy), 0);
        do_coin(50); do_coin(50); do_coin(10); do_coin(10);
        chk("t4_credit120", int'(credit), 120);
        do_coin(10);
        chk("t4_overflow_reject", int'(coin_reject), 1);
        chk("t4_credit_kept", int'(credit), 120);
        do_cancel();
        chk("t4_chg0", int'(change), 50);
        wait_idle();

        // product 1 runs out after three sales
        buy1(); buy1(); buy1();
        do_coin(10);
        do_sel(1);
        chk("t5_sold_out", int'(sold_out), 1);
        chk("t5_credit", int'(credit), 10);
`ifdef VENDING_RESTOCK_EN
        restock = 1'b1; restock_id = 3'd1;
        tick();
        restock = 1'b0; restock_id = '0;
        do_sel(1);
        chk("t5_restock_vend", int'(dispense_valid), 1);
        wait_idle();
`else
        do_cancel();
        wait_idle();
`endif

        // reset in the middle of a payout
        do_coin(50);
        do_sel(2);
        tick();
        chk("t6_pay_chg", int'(change), 10);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_cv", int'(change_valid), 0);
        chk("t6_rst_chg", int'(change), 0);
        chk("t6_rst_credit", int'(credit), 0);
        chk("t6_rst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        buy1(); buy1(); buy1();
        do_coin(10);
        do_sel(1);
        chk("t6_sold_out_after_3", int'(sold_out), 1);
        do_cancel();
        wait_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vending_machine_stock.md
# vending_machine_stock

Parametrised multi-product vending controller with per-product stock tracking and a multi-cycle coin-by-coin change payout FSM. It replaces the single-cycle change model of the earlier vending machine. It sits between coin-acceptor/keypad front-ends and the dispenser/change-hopper drivers. All event inputs are single-cycle strobes.

## Interface
- NUM_DRINKS, 4: number of products; valid selection IDs are 1..NUM_DRINKS, and 0 means no selection.
- SEL_W, 3: selection ID width; requires 2^SEL_W > NUM_DRINKS.
- CREDIT_W, 7: width of credit, coin and change values.
- STOCK_W, 4: width of each per-product stock counter.
- INIT_STOCK, 3: stock loaded into every product on reset; requires INIT_STOCK <= 2^STOCK_W-1.
- PRICE_BASE, 10: price of product 1.
- PRICE_STEP, 5: price increment per product ID, so price(k) = PRICE_BASE + (k-1)*PRICE_STEP.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coin  in  CREDIT_W  inserted coin value; legal values are 1, 5, 10, 50.
- coin_valid  in  1  coin strobe.
- sel  in  SEL_W  product selection ID.
- sel_valid  in  1  selection strobe.
- cancel  in  1  cancel strobe; returns all credit.
- restock  in  1  restock strobe (present only with VENDING_RESTOCK_EN).
- restock_id  in  SEL_W  product to refill (present only with VENDING_RESTOCK_EN).
- credit  out  CREDIT_W  current credit.
- dispense_valid  out  1  one-cycle vend pulse.
- dispense_id  out  SEL_W  product being vended; 0 when idle.
- change  out  CREDIT_W  coin being paid out; 0 when not paying.
- change_valid  out  1  qualifies change.
- coin_reject  out  1  one-cycle pulse: coin refused and returned.
- sel_error  out  1  one-cycle pulse: selection is 0 or above NUM_DRINKS.
- insufficient  out  1  one-cycle pulse: credit is below the product price.
- sold_out  out  1  one-cycle pulse: selected product stock is 0.
- busy  out  1  high outside IDLE.

## Operation
- FSM states and transitions:
  - IDLE: handles coin, sel and cancel events.
  - VEND: lasts exactly one cycle.
  - PAYOUT: pays out the remaining balance.
  - VEND goes to PAYOUT if the remainder is nonzero, else to IDLE.
- PAYOUT emits one coin per cycle, chosen greedily from 50, 10, 5, 1: the largest denomination not exceeding the remaining balance.
  - PAYOUT returns to IDLE after emitting the coin that brings the balance to 0.
- Event priority in IDLE is cancel > sel_valid > coin_valid. A losing coin in the same cycle pulses coin_reject; a losing sel is dropped silently.
- Coin handling:
  - A coin is accepted only in IDLE, only if it is a legal value, and only if credit + coin <= 2^CREDIT_W-1 (no wrap).
  - An accepted coin updates credit on the next edge.
  - Any other coin pulses coin_reject.
- Cancel with credit > 0: go to PAYOUT and return the full credit. Cancel with credit = 0: no effect.
- Selection checks, in order:
  - sel is 0 or above NUM_DRINKS: sel_error.
  - stock = 0: sold_out.
  - credit < price: insufficient.
  - In every failing case, credit and state are unchanged.
- Successful selection: go to VEND, stock[sel] decrements, and credit is reduced by the price.
- Credit is moved into the payout balance on entry to PAYOUT, so credit reads 0 throughout PAYOUT.
- Price arithmetic is computed at CREDIT_W+1 bits. Any product whose price is at or above 2^CREDIT_W reports insufficient.
- Reset mid-operation forces IDLE, clears credit and payout balance without paying out, and reloads all stock to INIT_STOCK.
- Reset values of all outputs: 0.

## Timing
- Let the event strobe be sampled at edge N.
- Status pulses (coin_reject, sel_error, insufficient, sold_out) are registered and high for the cycle after edge N.
- Successful selection:
  - dispense_valid is high for the cycle after edge N, with dispense_id = sel.
  - The first change coin is valid in the cycle after edge N+1.
  - A balance of B takes one cycle per greedy coin.
- Cancel: the first change coin is valid in the cycle after edge N.
- busy is high during VEND and PAYOUT. All strobes arriving then are ignored, except that coins pulse coin_reject.

## Configuration
- VENDING_RESTOCK_EN defined:
  - The restock and restock_id ports exist.
  - A restock strobe with a valid ID sets that product's stock to 2^STOCK_W-1 at the next edge, in any state.
  - If restock hits the same product as a same-cycle vend decrement, restock wins.
- VENDING_RESTOCK_EN undefined: the ports are absent and stock only ever decrements from INIT_STOCK.

## Structure
- Shared package vending_pkg holds:
  - the state enum (IDLE, VEND, PAYOUT);
  - the denomination constants 50, 10, 5, 1;
  - a price(k) function.
- Sub-module change_payout holds the greedy denomination picker and the balance register. Its handshake is load/balance in, coin/valid/done out.

## Test plan
- Coins 10, 5, 1, 10 (credit 26), then sel=3 (price 20) -> dispense_valid with id 3, then change 5 followed by 1, then credit 0.
- Coin 50, then sel=4 (price 25) -> dispense id 4, then change 10, 10, 5; stock[4] goes from 3 to 2.
- Credit 10, then sel=5 with NUM_DRINKS=4 -> sel_error, credit stays 10. Then cancel -> change 10, then idle with credit 0.
- Credit 0, sel=2 -> insufficient pulse with no state change. Credit 120 plus coin 10 -> coin_reject, credit stays 120.
- Buy product 1 three times with adequate credit, then a fourth time -> sold_out. With VENDING_RESTOCK_EN, restock_id=1 -> stock 15, and the next purchase vends.
- Assert rst_n low during PAYOUT -> all outputs 0 immediately, change stops, stock returns to 3.
